axi_lite_arbiter: RTL and testbench

- N-master to 1-slave AXI4-Lite arbiter, one level upstream of the address-decoding crossbar.
- Merges the instruction-fetch and load/store AXI-Lite masters into the single master port that feeds the crossbar.
- Allows one whole transaction (read or write) in flight at a time.
- Default arbitration is round-robin and transaction-granular.

---
 rtl/axi_lite_if.sv | 52 +++++
 rtl/axi_lite_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle shared by the arbiter and the crossbar.
// Ports (modport master drives requests, modport slave answers):
//   AR: araddr[31:0], arvalid, arready
//   R : rdata[31:0], rresp[1:0], rvalid, rready
//   AW: awaddr[31:0], awvalid, awready
//   W : wdata[31:0], wmask[3:0], wvalid, wready
//   B : bresp[1:0], bvalid, bready
interface axi_lite_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awaddr, awvalid,
        input  awready,
        output wdata, wmask, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awaddr, awvalid,
        output awready,
        input  wdata, wmask, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// N-to-1 AXI4-Lite arbiter merging IFU (0) and LSU (1) masters into the
// crossbar port; one whole read or write transaction in flight at a time.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   m[]   - upstream masters (axi_lite_if.slave), NUM_MASTERS entries
//   s     - downstream port to the crossbar (axi_lite_if.master)
// Build option: AXI_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) instead of the default transaction-granular round-robin.
module axi_lite_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input  logic       clk,
    input  logic       reset,
    axi_lite_if.slave  m [NUM_MASTERS],
    axi_lite_if.master s
);

    localparam int IW = $clog2(NUM_MASTERS);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t state, state_n;

    logic [IW-1:0] grant_idx, grant_n;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          aw_done, aw_done_n;
    logic          w_done, w_done_n;
    logic          txn_done;
    logic          aw_hs, w_hs;

    logic [NUM_MASTERS-1:0] m_arvalid, m_rready;
    logic [NUM_MASTERS-1:0] m_awvalid, m_wvalid, m_bready;
    logic [NUM_MASTERS-1:0] req;
    logic [31:0]            m_araddr [NUM_MASTERS];
    logic [31:0]            m_awaddr [NUM_MASTERS];
    logic [31:0]            m_wdata  [NUM_MASTERS];
    logic [3:0]             m_wmask  [NUM_MASTERS];

    logic [NUM_MASTERS-1:0] o_arready, o_rvalid;
    logic [NUM_MASTERS-1:0] o_awready, o_wready, o_bvalid;
    logic [31:0]            o_rdata [NUM_MASTERS];
    logic [1:0]             o_rresp [NUM_MASTERS];
    logic [1:0]             o_bresp [NUM_MASTERS];

    logic        s_arvalid, s_rready;
    logic        s_awvalid, s_wvalid, s_bready;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_wmask;

    // Interface arrays cannot be indexed by a runtime value, so flatten
    // each master into plain arrays that grant_idx can select from.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
        assign m_arvalid[i] = m[i].arvalid;
        assign m_araddr[i]  = m[i].araddr;
        assign m_rready[i]  = m[i].rready;
        assign m_awvalid[i] = m[i].awvalid;
        assign m_awaddr[i]  = m[i].awaddr;
        assign m_wvalid[i]  = m[i].wvalid;
        assign m_wdata[i]   = m[i].wdata;
        assign m_wmask[i]   = m[i].wmask;
        assign m_bready[i]  = m[i].bready;

        assign m[i].arready = o_arready[i];
        assign m[i].rvalid  = o_rvalid[i];
        assign m[i].rdata   = o_rdata[i];
        assign m[i].rresp   = o_rresp[i];
        assign m[i].awready = o_awready[i];
        assign m[i].wready  = o_wready[i];
        assign m[i].bvalid  = o_bvalid[i];
        assign m[i].bresp   = o_bresp[i];
    end

    assign s.arvalid = s_arvalid;
    assign s.araddr  = s_araddr;
    assign s.rready  = s_rready;
    assign s.awvalid = s_awvalid;
    assign s.awaddr  = s_awaddr;
    assign s.wvalid  = s_wvalid;
    assign s.wdata   = s_wdata;
    assign s.wmask   = s_wmask;
    assign s.bready  = s_bready;

    assign req = m_arvalid | m_awvalid;

    function automatic logic [IW-1:0] wrap_add(
        input logic [IW-1:0] base,
        input int            k
    );
        int t;
        t = (int'(base) + k) % NUM_MASTERS;
        return IW'(t);
    endfunction

    // First requester found scanning upward from rr_ptr with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!win_found && req[wrap_add(rr_ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant_idx;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        txn_done  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;

        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wmask   = '0;
        s_bready  = 1'b0;

        o_arready = '0;
        o_rvalid  = '0;
        o_awready = '0;
        o_wready  = '0;
        o_bvalid  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            o_rdata[i] = '0;
            o_rresp[i] = '0;
            o_bresp[i] = '0;
        end

        unique case (state)
            IDLE: begin
                if (win_found) begin
                    grant_n = win_idx;
                    // A read beats a write from the same master.
                    state_n = m_arvalid[win_idx] ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: begin
                s_arvalid = m_arvalid[grant_idx];
                s_araddr  = m_araddr[grant_idx];
                o_arready[grant_idx] = s.arready;
                if (s_arvalid && s.arready) begin
                    state_n = RD_DATA;
                end
            end
            RD_DATA: begin
                s_rready = m_rready[grant_idx];
                o_rvalid[grant_idx] = s.rvalid;
                o_rdata[grant_idx]  = s.rdata;
                o_rresp[grant_idx]  = s.rresp;
                if (s.rvalid && s_rready) begin
                    state_n  = IDLE;
                    txn_done = 1'b1;
                end
            end
            WR_REQ: begin
                // Each channel is masked once its handshake has happened
                // so a completed beat is never presented twice.
                s_awvalid = m_awvalid[grant_idx] & ~aw_done;
                s_awaddr  = m_awaddr[grant_idx];
                s_wvalid  = m_wvalid[grant_idx] & ~w_done;
                s_wdata   = m_wdata[grant_idx];
                s_wmask   = m_wmask[grant_idx];
                o_awready[grant_idx] = s.awready & ~aw_done;
                o_wready[grant_idx]  = s.wready & ~w_done;
                aw_hs = s_awvalid & s.awready;
                w_hs  = s_wvalid & s.wready;
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    state_n   = WR_RESP;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end else begin
                    aw_done_n = aw_done | aw_hs;
                    w_done_n  = w_done | w_hs;
                end
            end
            WR_RESP: begin
                s_bready = m_bready[grant_idx];
                o_bvalid[grant_idx] = s.bvalid;
                o_bresp[grant_idx]  = s.bresp;
                if (s.bvalid && s_bready) begin
                    state_n  = IDLE;
                    txn_done = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            state     <= state_n;
            grant_idx <= grant_n;
            aw_done   <= aw_done_n;
            w_done    <= w_done_n;
        end
    end

`ifdef AXI_ARB_FIXED_PRIO_EN
    // Scan always starts at master 0, so the lowest index wins.
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (txn_done) begin
            rr_ptr <= wrap_add(grant_idx, 1);
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: per-cycle vector table,
// a read scoreboard for arbitration order, and directed write/reset cases.
module tb_axi_lite_arbiter;

    localparam int N  = 2;
    localparam int NV = 13;
    localparam logic [31:0] A0  = 32'h0000_0000;
    localparam logic [31:0] A1  = 32'h8000_0010;
    localparam logic [31:0] KEY = 32'h5A5A_5A5A;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_lite_if m_if [N] ();
    axi_lite_if s_if ();

    axi_lite_arbiter #(.NUM_MASTERS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .m     (m_if),
        .s     (s_if)
    );

    logic [1:0]  m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [31:0] m_araddr [N];
    logic [31:0] m_awaddr [N];
    logic [31:0] m_wdata  [N];
    logic [3:0]  m_wmask  [N];

    logic [1:0]  mo_arready, mo_rvalid, mo_awready, mo_wready, mo_bvalid;
    logic [31:0] mo_rdata [N];
    logic [1:0]  mo_rresp [N];
    logic [1:0]  mo_bresp [N];

    logic        sl_arready, sl_rvalid, sl_awready, sl_wready, sl_bvalid;
    logic [31:0] sl_rdata;
    logic [1:0]  sl_rresp, sl_bresp;

    for (genvar i = 0; i < N; i++) begin : g_m
        assign m_if[i].arvalid = m_arvalid[i];
        assign m_if[i].araddr  = m_araddr[i];
        assign m_if[i].rready  = m_rready[i];
        assign m_if[i].awvalid = m_awvalid[i];
        assign m_if[i].awaddr  = m_awaddr[i];
        assign m_if[i].wvalid  = m_wvalid[i];
        assign m_if[i].wdata   = m_wdata[i];
        assign m_if[i].wmask   = m_wmask[i];
        assign m_if[i].bready  = m_bready[i];
        assign mo_arready[i]   = m_if[i].arready;
        assign mo_rvalid[i]    = m_if[i].rvalid;
        assign mo_rdata[i]     = m_if[i].rdata;
        assign mo_rresp[i]     = m_if[i].rresp;
        assign mo_awready[i]   = m_if[i].awready;
        assign mo_wready[i]    = m_if[i].wready;
        assign mo_bvalid[i]    = m_if[i].bvalid;
        assign mo_bresp[i]     = m_if[i].bresp;
    end

    assign s_if.arready = sl_arready;
    assign s_if.rvalid  = sl_rvalid;
    assign s_if.rdata   = sl_rdata;
    assign s_if.rresp   = sl_rresp;
    assign s_if.awready = sl_awready;
    assign s_if.wready  = sl_wready;
    assign s_if.bvalid  = sl_bvalid;
    assign s_if.bresp   = sl_bresp;

    typedef struct {
        logic [1:0]  arv;
        logic        sar;
        logic        srv;
        logic [31:0] srd;
        logic [1:0]  srr;
        logic        e_sarv;
        logic [31:0] e_addr;
        logic [1:0]  e_arr;
        logic [1:0]  e_rv;
        logic        e_srr;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rr0;
        logic [1:0]  e_rr1;
    } vec_t;

    typedef struct {
        int          mst;
        logic [31:0] data;
    } exp_t;

    vec_t vt [NV];
    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic [1:0]  arv,
        input logic        sar,
        input logic        srv,
        input logic [31:0] srd,
        input logic [1:0]  srr,
        input logic        e_sarv,
        input logic [31:0] e_addr,
        input logic [1:0]  e_arr,
        input logic [1:0]  e_rv,
        input logic        e_srr,
        input logic [31:0] e_rd0,
        input logic [31:0] e_rd1,
        input logic [1:0]  e_rr0,
        input logic [1:0]  e_rr1
    );
        vec_t v;
        v.arv = arv;       v.sar = sar;
        v.srv = srv;       v.srd = srd;
        v.srr = srr;       v.e_sarv = e_sarv;
        v.e_addr = e_addr; v.e_arr = e_arr;
        v.e_rv = e_rv;     v.e_srr = e_srr;
        v.e_rd0 = e_rd0;   v.e_rd1 = e_rd1;
        v.e_rr0 = e_rr0;   v.e_rr1 = e_rr1;
        return v;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        m_arvalid = '0; m_rready = '0; m_awvalid = '0;
        m_wvalid = '0;  m_bready = '0;
        for (int i = 0; i < N; i++) begin
            m_araddr[i] = '0; m_awaddr[i] = '0;
            m_wdata[i] = '0;  m_wmask[i] = '0;
        end
        sl_arready = 1'b0; sl_rvalid = 1'b0; sl_rdata = '0;
        sl_rresp = '0;     sl_awready = 1'b0; sl_wready = 1'b0;
        sl_bvalid = 1'b0;  sl_bresp = '0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        next();
        next();
        reset = 1'b0;
    endtask

    task automatic table_test();
        do_reset();
        m_rready = 2'b11;
        m_araddr[0] = A0;
        m_araddr[1] = A1;
        for (int i = 0; i < NV; i++) begin
            m_arvalid  = vt[i].arv;
            sl_arready = vt[i].sar;
            sl_rvalid  = vt[i].srv;
            sl_rdata   = vt[i].srd;
            sl_rresp   = vt[i].srr;
            @(negedge clk);
            chk($sformatf("v%0d s.arvalid", i),
                32'(s_if.arvalid), 32'(vt[i].e_sarv));
            chk($sformatf("v%0d s.araddr", i),
                s_if.araddr, vt[i].e_addr);
            chk($sformatf("v%0d m.arready", i),
                32'(mo_arready), 32'(vt[i].e_arr));
            chk($sformatf("v%0d m.rvalid", i),
                32'(mo_rvalid), 32'(vt[i].e_rv));
            chk($sformatf("v%0d s.rready", i),
                32'(s_if.rready), 32'(vt[i].e_srr));
            chk($sformatf("v%0d m0.rdata", i),
                mo_rdata[0], vt[i].e_rd0);
            chk($sformatf("v%0d m1.rdata", i),
                mo_rdata[1], vt[i].e_rd1);
            chk($sformatf("v%0d m0.rresp", i),
                32'(mo_rresp[0]), 32'(vt[i].e_rr0));
            chk($sformatf("v%0d m1.rresp", i),
                32'(mo_rresp[1]), 32'(vt[i].e_rr1));
            next();
        end
    endtask

    task automatic rr_test();
        logic [31:0] addr [N];
        logic        pend;
        logic [31:0] pdata;
        int          pops;
        int          last;
        do_reset();
        sbq.delete();
        addr[0] = 32'h1000;
        addr[1] = 32'h2000;
        for (int t = 0; t < 4; t++) begin
            int          mst;
            logic [31:0] a;
`ifdef AXI_ARB_FIXED_PRIO_EN
            mst = 0;
            a   = 32'h1000 + 32'(4 * t);
`else
            mst = t % 2;
            a   = (mst == 0) ? 32'h1000 : 32'h2000;
            a   = a + 32'(4 * (t / 2));
`endif
            sbq.push_back('{mst, a ^ KEY});
        end
        pend  = 1'b0;
        pdata = '0;
        pops  = 0;
        last  = -1;
        m_rready = 2'b11;
        for (int c = 0; c < 40 && pops < 4; c++) begin
            m_arvalid   = 2'b11;
            m_araddr[0] = addr[0];
            m_araddr[1] = addr[1];
            sl_arready  = 1'b1;
            sl_rvalid   = pend;
            sl_rdata    = pdata;
            @(negedge clk);
            if (sl_rvalid && s_if.rready) pend = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (mo_rvalid[i] && m_rready[i]) begin
                    exp_t e;
                    if (sbq.size() == 0) begin
                        chk("rr extra beat", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("rr%0d master", pops),
                            32'(i), 32'(e.mst));
                        chk($sformatf("rr%0d rdata", pops),
                            mo_rdata[i], e.data);
                        pops++;
                        last = c;
                    end
                end
            end
            if (s_if.arvalid && sl_arready) begin
                pend  = 1'b1;
                pdata = s_if.araddr ^ KEY;
            end
            for (int i = 0; i < N; i++) begin
                if (mo_arready[i] && m_arvalid[i]) begin
                    addr[i] = addr[i] + 32'd4;
                end
            end
            next();
        end
        chk("rr beats done", 32'(pops), 32'd4);
        chk("rr last beat cycle", 32'(last), 32'd11);
    endtask

    task automatic write_test();
        do_reset();
        m_awvalid = 2'b01; m_awaddr[0] = 32'ha000_03f8;
        m_wvalid = 2'b01;  m_wdata[0] = 32'h41;
        m_wmask[0] = 4'h1; m_bready = 2'b11;
        @(negedge clk);
        chk("w0 s.awvalid", 32'(s_if.awvalid), 32'd0);
        chk("w0 s.wvalid", 32'(s_if.wvalid), 32'd0);
        next();
        sl_wready = 1'b1;
        @(negedge clk);
        chk("w1 s.awvalid", 32'(s_if.awvalid), 32'd1);
        chk("w1 s.wvalid", 32'(s_if.wvalid), 32'd1);
        chk("w1 s.awaddr", s_if.awaddr, 32'ha000_03f8);
        chk("w1 s.wdata", s_if.wdata, 32'h41);
        chk("w1 s.wmask", 32'(s_if.wmask), 32'h1);
        chk("w1 m.wready", 32'(mo_wready), 32'h1);
        chk("w1 m.awready", 32'(mo_awready), 32'h0);
        next();
        @(negedge clk);
        chk("w2 s.wvalid", 32'(s_if.wvalid), 32'd0);
        chk("w2 m.wready", 32'(mo_wready), 32'h0);
        chk("w2 s.awvalid", 32'(s_if.awvalid), 32'd1);
        chk("w2 s.bready", 32'(s_if.bready), 32'd0);
        next();
        sl_awready = 1'b1; sl_wready = 1'b0;
        @(negedge clk);
        chk("w3 m.awready", 32'(mo_awready), 32'h1);
        chk("w3 s.bready", 32'(s_if.bready), 32'd0);
        next();
        m_awvalid = '0; m_wvalid = '0; sl_awready = 1'b0;
        sl_bvalid = 1'b1; sl_bresp = 2'b00;
        @(negedge clk);
        chk("w4 s.bready", 32'(s_if.bready), 32'd1);
        chk("w4 m.bvalid", 32'(mo_bvalid), 32'h1);
        chk("w4 m0.bresp", 32'(mo_bresp[0]), 32'h0);
        chk("w4 s.awvalid", 32'(s_if.awvalid), 32'd0);
        next();
        sl_bvalid = 1'b0;
        @(negedge clk);
        chk("w5 s.bready", 32'(s_if.bready), 32'd0);
        chk("w5 m.bvalid", 32'(mo_bvalid), 32'h0);
        next();
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_wdata[0] = 32'h42;
        @(negedge clk);
        chk("x0 s.awvalid", 32'(s_if.awvalid), 32'd0);
        next();
        sl_awready = 1'b1; sl_wready = 1'b1;
        @(negedge clk);
        chk("x1 s.awvalid", 32'(s_if.awvalid), 32'd1);
        chk("x1 s.wvalid", 32'(s_if.wvalid), 32'd1);
        chk("x1 m.awready", 32'(mo_awready), 32'h1);
        chk("x1 m.wready", 32'(mo_wready), 32'h1);
        next();
        m_awvalid = '0; m_wvalid = '0;
        sl_awready = 1'b0; sl_wready = 1'b0;
        @(negedge clk);
        chk("x2 s.bready", 32'(s_if.bready), 32'd1);
        chk("x2 m.bvalid", 32'(mo_bvalid), 32'h0);
        next();
        sl_bvalid = 1'b1; sl_bresp = 2'b10;
        @(negedge clk);
        chk("x3 m.bvalid", 32'(mo_bvalid), 32'h1);
        chk("x3 m0.bresp", 32'(mo_bresp[0]), 32'h2);
        chk("x3 m1.bresp", 32'(mo_bresp[1]), 32'h0);
        next();
        sl_bvalid = 1'b0; sl_bresp = 2'b00;
        @(negedge clk);
        chk("x4 s.bready", 32'(s_if.bready), 32'd0);
        next();
    endtask

    task automatic conflict_test();
        do_reset();
        m_rready = 2'b11;  m_bready = 2'b11;
        m_arvalid = 2'b10; m_araddr[1] = 32'h3000;
        m_awvalid = 2'b10; m_awaddr[1] = 32'h4000;
        m_wvalid = 2'b10;  m_wdata[1] = 32'h55;
        m_wmask[1] = 4'hF;
        @(negedge clk);
        chk("y0 s.arvalid", 32'(s_if.arvalid), 32'd0);
        next();
        sl_arready = 1'b1;
        @(negedge clk);
        chk("y1 s.arvalid", 32'(s_if.arvalid), 32'd1);
        chk("y1 s.awvalid", 32'(s_if.awvalid), 32'd0);
        chk("y1 s.araddr", s_if.araddr, 32'h3000);
        chk("y1 m.arready", 32'(mo_arready), 32'h2);
        next();
        m_arvalid = '0; sl_arready = 1'b0;
        sl_rvalid = 1'b1; sl_rdata = 32'h77;
        @(negedge clk);
        chk("y2 m.rvalid", 32'(mo_rvalid), 32'h2);
        chk("y2 m1.rdata", mo_rdata[1], 32'h77);
        chk("y2 s.awvalid", 32'(s_if.awvalid), 32'd0);
        next();
        sl_rvalid = 1'b0;
        @(negedge clk);
        chk("y3 s.awvalid", 32'(s_if.awvalid), 32'd0);
        next();
        sl_awready = 1'b1; sl_wready = 1'b1;
        @(negedge clk);
        chk("y4 s.awvalid", 32'(s_if.awvalid), 32'd1);
        chk("y4 s.awaddr", s_if.awaddr, 32'h4000);
        chk("y4 s.wdata", s_if.wdata, 32'h55);
        chk("y4 s.wmask", 32'(s_if.wmask), 32'hF);
        chk("y4 m.awready", 32'(mo_awready), 32'h2);
        next();
        m_awvalid = '0; m_wvalid = '0;
        sl_awready = 1'b0; sl_wready = 1'b0; sl_bvalid = 1'b1;
        @(negedge clk);
        chk("y5 m.bvalid", 32'(mo_bvalid), 32'h2);
        next();
        sl_bvalid = 1'b0;
        @(negedge clk);
        chk("y6 s.bready", 32'(s_if.bready), 32'd0);
        next();
    endtask

    task automatic reset_mid_test();
        do_reset();
        m_rready = 2'b11;
        m_arvalid = 2'b01; m_araddr[0] = 32'h5000;
        @(negedge clk);
        next();
        sl_arready = 1'b1;
        @(negedge clk);
        chk("z1 s.arvalid", 32'(s_if.arvalid), 32'd1);
        next();
        m_arvalid = '0; sl_arready = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("z2 s.rready", 32'(s_if.rready), 32'd1);
        next();
        reset = 1'b0;
        m_arvalid = 2'b10; m_araddr[1] = 32'h6000;
        @(negedge clk);
        chk("z3 s.rready", 32'(s_if.rready), 32'd0);
        chk("z3 s.arvalid", 32'(s_if.arvalid), 32'd0);
        chk("z3 m.rvalid", 32'(mo_rvalid), 32'h0);
        chk("z3 m.arready", 32'(mo_arready), 32'h0);
        next();
        sl_arready = 1'b1;
        @(negedge clk);
        chk("z4 s.arvalid", 32'(s_if.arvalid), 32'd1);
        chk("z4 s.araddr", s_if.araddr, 32'h6000);
        chk("z4 m.arready", 32'(mo_arready), 32'h2);
        next();
        m_arvalid = '0; sl_arready = 1'b0;
        sl_rvalid = 1'b1; sl_rdata = 32'h99;
        @(negedge clk);
        chk("z5 m.rvalid", 32'(mo_rvalid), 32'h2);
        chk("z5 m1.rdata", mo_rdata[1], 32'h99);
        next();
    endtask

    initial begin
        vt[0]  = mk(2'b00, 1'b0, 1'b0, 32'h0, 2'b00,
                    1'b0, 32'h0, 2'b00, 2'b00, 1'b0,
                    32'h0, 32'h0, 2'b00, 2'b00);
        vt[1]  = mk(2'b10, 1'b0, 1'b0, 32'h0, 2'b00,
                    1'b0, 32'h0, 2'b00, 2'b00, 1'b0,
                    32'h0, 32'h0, 2'b00, 2'b00);
        vt[2]  = mk(2'b10, 1'b1, 1'b0, 32'h0, 2'b00,
                    1'b1, A1, 2'b10, 2'b00, 1'b0,
                    32'h0, 32'h0, 2'b00, 2'b00);
        vt[3]  = mk(2'b00, 1'b0, 1'b0, 32'h0, 2'b00,
                    1'b0, 32'h0, 2'b00, 2'b00, 1'b1,
                    32'h0, 32'h0, 2'b00, 2'b00);
        vt[4]  = mk(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b00,
                    1'b0, 32'h0, 2'b00, 2'b10, 1'b1,
                    32'h0, 32'hDEAD_BEEF, 2'b00, 2'b00);
        vt[5]  = mk(2'b00, 1'b0, 1'b0, 32'h0, 2'b00,
                    1'b0, 32'h0, 2'b00, 2'b00, 1'b0,
                    32'h0, 32'h0, 2'b00, 2'b00);
        vt[6]  = mk(2'b11, 1'b0, 1'b0, 32'h0, 2'b00,
                    1'b0, 32'h0, 2'b00, 2'b00, 1'b0,
                    32'h0, 32'h0, 2'b00, 2'b00);
        vt[7]  = mk(2'b11, 1'b1, 1'b0, 32'h0, 2'b00,
                    1'b1, A0, 2'b01, 2'b00, 1'b0,
                    32'h0, 32'h0, 2'b00, 2'b00);
        vt[8]  = mk(2'b10, 1'b0, 1'b1, 32'h0, 2'b11,
                    1'b0, 32'h0, 2'b00, 2'b01, 1'b1,
                    32'h0, 32'h0, 2'b11, 2'b00);
        vt[9]  = mk(2'b10, 1'b0, 1'b0, 32'h0, 2'b00,
                    1'b0, 32'h0, 2'b00, 2'b00, 1'b0,
                    32'h0, 32'h0, 2'b00, 2'b00);
        vt[10] = mk(2'b10, 1'b1, 1'b0, 32'h0, 2'b00,
                    1'b1, A1, 2'b10, 2'b00, 1'b0,
                    32'h0, 32'h0, 2'b00, 2'b00);
        vt[11] = mk(2'b00, 1'b0, 1'b1, 32'hCAFE_0001, 2'b00,
                    1'b0, 32'h0, 2'b00, 2'b10, 1'b1,
                    32'h0, 32'hCAFE_0001, 2'b00, 2'b00);
        vt[12] = mk(2'b00, 1'b0, 1'b0, 32'h0, 2'b00,
                    1'b0, 32'h0, 2'b00, 2'b00, 1'b0,
                    32'h0, 32'h0, 2'b00, 2'b00);

        clr();
        reset = 1'b1;
        m_arvalid = 2'b11; m_awvalid = 2'b11; m_wvalid = 2'b11;
        m_rready = 2'b11;  m_bready = 2'b11;
        sl_arready = 1'b1; sl_rvalid = 1'b1; sl_rdata = 32'hFFFF_FFFF;
        sl_rresp = 2'b11;  sl_awready = 1'b1; sl_wready = 1'b1;
        sl_bvalid = 1'b1;  sl_bresp = 2'b11;
        next();
        next();
        @(negedge clk);
        chk("rst s valids", 32'({s_if.arvalid, s_if.rready,
            s_if.awvalid, s_if.wvalid, s_if.bready}), 32'h0);
        chk("rst s.araddr", s_if.araddr, 32'h0);
        chk("rst s.wdata", s_if.wdata, 32'h0);
        chk("rst m readies", 32'({mo_arready, mo_awready,
            mo_wready}), 32'h0);
        chk("rst m valids", 32'({mo_rvalid, mo_bvalid}), 32'h0);
        chk("rst m0.rdata", mo_rdata[0], 32'h0);
        chk("rst m1.bresp", 32'(mo_bresp[1]), 32'h0);

        table_test();
        write_test();
        rr_test();
        conflict_test();
        reset_mid_test();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
